display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexes the four-digit seven-segment display for the Lab3 calculator result path.
- Accepts a 3-digit BCD magnitude (hundreds 0-3, tens, ones) plus sign and overflow flags, with a load strobe.
- Double-buffers the value so digits never tear mid-frame, sequences the anodes with an anti-ghosting blank interval, and decodes each digit onto the shared segment bus.

Parameters:
DWELL_CYCLES, 100000, clock cycles each digit slot lasts (100 MHz -> 1 kHz per digit); must be >= BLANK_CYCLES+2
BLANK_CYCLES, 4, cycles at start of each slot with all anodes off; must be >= 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
BCD_digit  input  10  [9:8] hundreds, [7:4] tens, [3:0] ones
sign  input  1  1 = negative result
overflow  input  1  1 = result out of range
load  input  1  one-cycle strobe; capture BCD_digit/sign/overflow
digit_anode  output  4  active-low anode enables, bit 0 = rightmost digit
segment  output  7  active-low, bit order {g,f,e,d,c,b,a}
frame_tick  output  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State registers:
  - slot counter cnt, 0..DWELL_CYCLES-1
  - digit index idx, 0..3, scan order 0->1->2->3->0
  - pending buffer plus pend_flag
  - active buffer
- Output timing: outputs are combinational decode of registers only. No input-to-output combinational path.
- Reset, effective at the next clk edge:
  - cnt=0, idx=0, pend_flag=0, active buffer all zeros (displays "   0").
  - While rst is high, digit_anode=4'b1111, segment=7'h7F, frame_tick=0.
- Counter:
  - cnt increments every cycle.
  - At cnt==DWELL_CYCLES-1: cnt<=0 and idx<=idx+1, wrapping 3->0.
- Anodes:
  - If cnt < BLANK_CYCLES: digit_anode=4'b1111 and segment=7'h7F.
  - Otherwise only bit idx of digit_anode is driven low.
- frame_tick: high exactly in the cycle where idx==3 and cnt==DWELL_CYCLES-1 (commit cycle).
- Buffering:
  - load=1 writes pending and sets pend_flag.
  - In the commit cycle, if pend_flag=1, active<=pending and pend_flag<=0.
  - If load=1 in the commit cycle, the incoming values are committed directly to active and pend_flag ends at 0.
  - Multiple loads within one frame: the last one wins.
  - A load takes effect on the display starting at the next frame's idx=0 slot.
- Digit content, from the active buffer:
  - overflow=1: digits 3..0 = blank, E, r, r (" Err"). Sign is ignored.
  - Otherwise:
    - digit3 = '-' if sign, else blank.
    - digit2 = hundreds, blanked if hundreds==0.
    - digit1 = tens, blanked if hundreds==0 and tens==0.
    - digit0 = ones, always shown.
  - A tens or ones nibble > 9 displays E. Leading-zero blanking treats such a nibble as nonzero.
- Segment codes, active-low hex:
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Symbols: '-'=3F, E=06, r=2F, blank=7F.
  - For a blank digit, the anode is still driven low in its slot while segment=7F.
- Reset mid-operation discards pending and active contents. Scanning restarts at idx=0 with cnt=0, in the blank phase.

Test Plan:
Bench runs with DWELL_CYCLES=8, BLANK_CYCLES=2.
1. Reset release, no load -> first frame:
   - digit_anode=1111 on cycles 0-1, 1110 with segment=40 on cycles 2-7.
   - Slots 1-3 have their anode low from cnt=2 with segment=7F.
   - frame_tick high only at cycle 31; period is 32 cycles.
2. load BCD_digit=10'h123 (1,2,3), sign=1 at cycle 5:
   - Frame 0 unchanged.
   - From cycle 32, slots show digit0=30, digit1=24, digit2=79, digit3=3F.
3. Leading-zero blanking:
   - load 10'h005, sign=0 -> digits 3..1=7F, digit0=12.
   - load 10'h105 -> digit2=79, digit1=40, digit0=12.
   - load 10'h0A5 -> digit1=06.
4. Overflow: load with overflow=1, sign=1, BCD_digit=10'h123 -> digits 3..0 = 7F, 06, 2F, 2F.
5. Buffering edge cases:
   - load 10'h111 at idx=1, then 10'h222 at idx=2 -> next frame shows 222.
   - load 10'h333 exactly in the frame_tick cycle -> next frame shows 333, pend_flag=0.
6. Reset mid-scan: assert rst for 1 cycle at idx=2, cnt=5 ->
   - Next cycle: digit_anode=1111, cnt=0, idx=0.
   - Display returns to "   0" and the prior load is lost.

Source files
------------

// File: rtl/display_scan_if.sv
// Calculator-result to seven-segment display bus: value/flags/load in, anode/segment/tick out.
interface display_scan_if;
   logic [9:0] BCD_digit;
   logic       sign;
   logic       overflow;
   logic       load;
   logic [3:0] digit_anode;
   logic [6:0] segment;
   logic       frame_tick;

   // Producer of result values; observer of the display drive
   modport master (
      output BCD_digit, sign, overflow, load,
      input  digit_anode, segment, frame_tick
   );

   // Display scan controller side
   modport slave (
      input  BCD_digit, sign, overflow, load,
      output digit_anode, segment, frame_tick
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous double buffering.
module display_scan_ctrl #(
   parameter int unsigned DWELL_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   display_scan_if.slave bus
);

   localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;

   typedef struct packed {
      logic       overflow;
      logic       sign;
      logic [1:0] hund;
      logic [3:0] tens;
      logic [3:0] ones;
   } disp_val_t;

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_idx;
   disp_val_t        r_pend;
   logic             r_pend_flag;
   disp_val_t        r_act;
   logic             r_in_rst;

   disp_val_t        w_in;
   logic             w_commit;
   logic             w_blank;
   logic [6:0]       w_digit_seg;
   logic [3:0]       w_anode;
   logic [6:0]       w_seg;
   logic             w_tick;

   // Active-low segment pattern for one decimal nibble; anything above 9 shows E
   function automatic logic [6:0] seg_digit(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_E;
      endcase
      return s;
   endfunction

   assign w_in = '{overflow: bus.overflow,
                   sign:     bus.sign,
                   hund:     bus.BCD_digit[9:8],
                   tens:     bus.BCD_digit[7:4],
                   ones:     bus.BCD_digit[3:0]};

   // Last cycle of the last slot is the only point where the shown value may change
   assign w_commit = (r_idx == 2'd3) && (r_cnt == CNT_LAST);
   assign w_blank  = (r_cnt < CNT_BLANK);

   // Slot counter and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Pending/active double buffer; a load in the commit cycle bypasses pending
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend      <= '0;
         r_pend_flag <= 1'b0;
         r_act       <= '0;
      end else begin
         if (bus.load) begin
            r_pend <= w_in;
         end
         if (w_commit) begin
            if (bus.load) begin
               r_act <= w_in;
            end else if (r_pend_flag) begin
               r_act <= r_pend;
            end
            r_pend_flag <= 1'b0;
         end else if (bus.load) begin
            r_pend_flag <= 1'b1;
         end
      end
   end

   // Remembers that the last edge was a reset edge so the display stays dark
   always_ff @(posedge clk) begin
      r_in_rst <= rst;
   end

   // Glyph for the digit currently being scanned, with leading-zero blanking
   always_comb begin
      w_digit_seg = SEG_BLANK;
      if (r_act.overflow) begin
         case (r_idx)
            2'd3:    w_digit_seg = SEG_BLANK;
            2'd2:    w_digit_seg = SEG_E;
            default: w_digit_seg = SEG_R;
         endcase
      end else begin
         case (r_idx)
            2'd3: w_digit_seg = r_act.sign ? SEG_DASH : SEG_BLANK;
            2'd2: w_digit_seg = (r_act.hund == 2'd0) ? SEG_BLANK
                                                     : seg_digit({2'b00, r_act.hund});
            2'd1: w_digit_seg = ((r_act.hund == 2'd0) && (r_act.tens == 4'd0)) ? SEG_BLANK
                                                     : seg_digit(r_act.tens);
            default: w_digit_seg = seg_digit(r_act.ones);
         endcase
      end
   end

   // Anode/segment drive from registered state only
   always_comb begin
      w_anode = 4'b1111;
      w_seg   = SEG_BLANK;
      w_tick  = 1'b0;
      if (!r_in_rst) begin
         w_tick = w_commit;
         if (!w_blank) begin
            w_anode = ~(4'b0001 << r_idx);
            w_seg   = w_digit_seg;
         end
      end
   end

   assign bus.digit_anode = w_anode;
   assign bus.segment     = w_seg;
   assign bus.frame_tick  = w_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with a short dwell so frames are 32 cycles.
module tb_display_scan_ctrl;

   localparam int unsigned DWELL  = 8;
   localparam int unsigned BLANK  = 2;
   localparam int unsigned FRAME  = 4 * DWELL;
   localparam int unsigned N_CYC  = 350;

   typedef struct packed {
      logic [3:0] anode;
      logic [6:0] seg;
      logic       tick;
   } exp_t;

   typedef struct {
      int         cyc;
      logic       do_rst;
      logic [9:0] bcd;
      logic       sgn;
      logic       ovf;
   } stim_t;

   logic clk = 1'b0;
   logic rst;

   display_scan_if bus ();

   display_scan_ctrl #(
      .DWELL_CYCLES(DWELL),
      .BLANK_CYCLES(BLANK)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   // Single comparison point for every check in the bench
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      logic [6:0] tbl [10];
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      if (n > 4'd9) return 7'h06;
      return tbl[n];
   endfunction

   // Expected glyphs {digit3, digit2, digit1, digit0} for a loaded value
   function automatic logic [27:0] ref_img(input logic [9:0] b, input logic s, input logic o);
      logic [6:0] d3, d2, d1, d0;
      logic [3:0] h, t, u;
      h = {2'b00, b[9:8]};
      t = b[7:4];
      u = b[3:0];
      if (o) begin
         d3 = 7'h7F; d2 = 7'h06; d1 = 7'h2F; d0 = 7'h2F;
      end else begin
         d3 = s ? 7'h3F : 7'h7F;
         d2 = (h == 4'd0) ? 7'h7F : ref_seg(h);
         d1 = (h == 4'd0 && t == 4'd0) ? 7'h7F : ref_seg(t);
         d0 = ref_seg(u);
      end
      return {d3, d2, d1, d0};
   endfunction

   stim_t stim [11];

   initial begin
      int          t;
      logic [27:0] cur_img;
      logic [27:0] pend_img;
      logic        pend_v;
      int          slot;
      int          c;
      exp_t        e;
      exp_t        got;
      logic        ld;
      logic        rs;
      string       tag;

      stim[0]  = '{5,             1'b0, 10'h123, 1'b1, 1'b0};
      stim[1]  = '{32 + 4,        1'b0, 10'h005, 1'b0, 1'b0};
      stim[2]  = '{64 + 12,       1'b0, 10'h105, 1'b0, 1'b0};
      stim[3]  = '{96 + 20,       1'b0, 10'h0A5, 1'b0, 1'b0};
      stim[4]  = '{128 + 3,       1'b0, 10'h123, 1'b1, 1'b1};
      stim[5]  = '{160 + 10,      1'b0, 10'h111, 1'b0, 1'b0};
      stim[6]  = '{160 + 18,      1'b0, 10'h222, 1'b0, 1'b0};
      stim[7]  = '{192 + 31,      1'b0, 10'h333, 1'b0, 1'b0};
      stim[8]  = '{224 + 7,       1'b0, 10'h00C, 1'b0, 1'b0};
      stim[9]  = '{256 + 9,       1'b0, 10'h399, 1'b1, 1'b0};
      stim[10] = '{256 + 21,      1'b1, 10'h000, 1'b0, 1'b0};

      rst              = 1'b1;
      bus.load         = 1'b0;
      bus.BCD_digit    = '0;
      bus.sign         = 1'b0;
      bus.overflow     = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_anode", 32'(bus.digit_anode), 32'h0000000F);
      check("rst_seg",   32'(bus.segment),     32'h0000007F);
      check("rst_tick",  32'(bus.frame_tick),  32'h00000000);
      @(posedge clk);

      t        = 0;
      cur_img  = ref_img(10'h000, 1'b0, 1'b0);
      pend_img = '0;
      pend_v   = 1'b0;

      for (int n = 0; n < int'(N_CYC); n++) begin
         #1;
         ld = 1'b0;
         rs = 1'b0;
         bus.load = 1'b0;
         foreach (stim[k]) begin
            if (stim[k].cyc == n) begin
               if (stim[k].do_rst) begin
                  rs = 1'b1;
               end else begin
                  ld            = 1'b1;
                  bus.BCD_digit = stim[k].bcd;
                  bus.sign      = stim[k].sgn;
                  bus.overflow  = stim[k].ovf;
                  pend_img      = ref_img(stim[k].bcd, stim[k].sgn, stim[k].ovf);
               end
            end
         end
         bus.load = ld;
         rst      = rs;

         // Expected drive for this cycle, from the frame-level model
         if (!rs) begin
            c    = t % int'(DWELL);
            slot = (t % int'(FRAME)) / int'(DWELL);
            if (c < int'(BLANK)) begin
               e.anode = 4'b1111;
               e.seg   = 7'h7F;
            end else begin
               e.anode = 4'b1111;
               e.anode[slot] = 1'b0;
               e.seg   = cur_img[slot*7 +: 7];
            end
            e.tick = ((t % int'(FRAME)) == int'(FRAME) - 1);
            sb_q.push_back(e);
         end

         @(negedge clk);
         if (!rs) begin
            got = '{bus.digit_anode, bus.segment, bus.frame_tick};
            tag = $sformatf("cyc%0d", n);
            if (sb_q.size() == 0) begin
               check({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
               e = sb_q.pop_front();
               check({tag, "_anode"}, 32'(got.anode), 32'(e.anode));
               check({tag, "_seg"},   32'(got.seg),   32'(e.seg));
               check({tag, "_tick"},  32'(got.tick),  32'(e.tick));
            end
         end

         // Advance the model across the coming clock edge
         if (rs) begin
            t       = 0;
            cur_img = ref_img(10'h000, 1'b0, 1'b0);
            pend_v  = 1'b0;
         end else begin
            if (ld) pend_v = 1'b1;
            t++;
            if ((t % int'(FRAME)) == 0 && pend_v) begin
               cur_img = pend_img;
               pend_v  = 1'b0;
            end
         end
         @(posedge clk);
      end

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
